mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk` (input, 1) is the rising-edge clock; `reset` (input, 1) is asynchronous and active-low.
REQ-002 `req_valid` SHALL be input, 1 bit: a CPU request is present.
REQ-003 `req_ready` SHALL be output, 1 bit: the unit accepts a request.
REQ-004 `req_we` SHALL be input, 1 bit: 1 = store, 0 = load.
REQ-005 `req_size` SHALL be input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-006 `req_signed` SHALL be input, 1 bit: sign-extend load data.
REQ-007 `req_addr` SHALL be input, 24 bits: byte address.
REQ-008 `req_wdata` SHALL be input, 32 bits: store data, right-aligned.
REQ-009 `resp_valid` SHALL be output, 1 bit: a response is present.
REQ-010 `resp_ready` SHALL be input, 1 bit: the CPU takes the response.
REQ-011 `resp_rdata` SHALL be output, 32 bits: load result; 0 for stores.
REQ-012 `resp_err` SHALL be output, 1 bit: the request was rejected.
REQ-013 `address` SHALL be output, 22 bits: word address to dataMem, equal to `req_addr[23:2]`.
REQ-014 `dataIn` SHALL be output, 32 bits: write word to dataMem.
REQ-015 `writeEnable` SHALL be output, 1 bit: dataMem write strobe.
REQ-016 `dataOut` SHALL be input, 32 bits: dataMem read word, combinationally valid for the current `address`.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, READ, WRITE, RESP.
REQ-018 IDLE: `req_ready` = 1; a request is accepted on a clock edge with `req_valid` & `req_ready`, and all `req_*` fields are captured.
REQ-019 Transitions from IDLE on acceptance SHALL be:
- error condition (REQ-025 or macro trap) → RESP with `resp_err` = 1;
- load → READ;
- word store → WRITE;
- byte or half store → READ (read-modify-write).
REQ-020 READ: `writeEnable` = 0 and `dataOut` is sampled at the edge.
- Load: extract data and go to RESP.
- Store: merge the store data into the sampled word and go to WRITE.
REQ-021 WRITE: `writeEnable` SHALL be 1 for exactly one cycle with `dataIn` holding the final word, then go to RESP with `resp_rdata` = 0.
REQ-022 RESP: `resp_valid` = 1, and `resp_rdata` and `resp_err` SHALL be held stable until `resp_ready` = 1; the state then returns to IDLE; `req_ready` = 0 in every state except IDLE.
REQ-023 Byte lanes SHALL be little-endian:
- byte lane = `addr[1:0]`, bits [8k+7:8k];
- half lane = `addr[1]`;
- loads are zero-extended, or sign-extended when `req_signed` = 1.
REQ-024 Latency from the acceptance edge to `resp_valid` high SHALL be:
- load: 2 cycles;
- word store: 2 cycles;
- sub-word store: 3 cycles;
- error: 1 cycle.
REQ-025 `req_size` = 11 SHALL produce `resp_err` = 1 with no memory access.
REQ-026 `writeEnable` SHALL be a registered output and SHALL be 0 in every state except WRITE.
REQ-027 `address` and `dataIn` SHALL be stable throughout READ and WRITE.

Reset
REQ-028 While `reset` = 0 (asynchronous), the unit SHALL hold:
- state = IDLE;
- `writeEnable` = 0, `resp_valid` = 0, `resp_err` = 0;
- `resp_rdata`, `address`, `dataIn` = 0;
- no request accepted.
REQ-029 Reset asserted mid-operation SHALL drop `writeEnable` immediately and discard the pending response; after release the unit SHALL be in IDLE with `req_ready` = 1.

Configuration
REQ-030 With `MISALIGN_TRAP_EN` defined, a misaligned request SHALL return `resp_err` = 1 with no memory access. A request is misaligned if:
- it is a half access with `addr[0]` = 1; or
- it is a word access with `addr[1:0]` ≠ 0.
REQ-031 Without `MISALIGN_TRAP_EN`, the unit SHALL ignore the low address bits that break alignment (force the access aligned) and SHALL never raise an error for misalignment.

Verification
REQ-032 Word store of 0xDEADBEEF to 0x000010, then word load from 0x000010 → `address` = 0x000004, `writeEnable` high exactly 1 cycle, `resp_rdata` = 0xDEADBEEF.
REQ-033 Word 0x11223344 at 0x000010, then byte store of 0xAA to 0x000011 → memory word = 0x1122AA44. Then:
- signed byte load from 0x000011 → 0xFFFFFFAA;
- unsigned byte load from 0x000011 → 0x000000AA.
REQ-034 Word 0x8001BEEF at 0x000010, signed half load from 0x000012 → 0xFFFF8001; unsigned → 0x00008001.
REQ-035 `resp_ready` held low for 5 cycles after a load → `resp_valid` and `resp_rdata` stable, `req_ready` = 0, `writeEnable` = 0 throughout.
REQ-036 Word load at 0x000002:
- with the macro: `resp_err` = 1 one cycle after acceptance, no READ state;
- without the macro: returns the word at 0x000000.
REQ-037 `reset` driven low during WRITE → `writeEnable` = 0 in the same cycle, no `resp_valid`; after release, `req_ready` = 1 and the next load completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// CPU request/response channel and dataMem port of the memory access unit.
// The slave modport is the unit's view; master is the CPU/memory side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [21:0] address;
    logic [31:0] dataIn;
    logic        writeEnable;
    logic [31:0] dataOut;

    modport slave (
        input  req_valid, req_we, req_size, req_signed,
        input  req_addr, req_wdata, resp_ready, dataOut,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output address, dataIn, writeEnable
    );

    modport master (
        output req_valid, req_we, req_size, req_signed,
        output req_addr, req_wdata, resp_ready, dataOut,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  address, dataIn, writeEnable
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU and a word-wide dataMem, with byte/half read-modify-write.
// Build option: MISALIGN_TRAP_EN rejects misaligned half/word requests instead of aligning them.
module mem_access_unit (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [21:0] r_address;
    logic [31:0] r_dataIn;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_wen;

    logic        w_accept;
    logic        w_misalign;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_accept = bus.req_valid & (r_state == S_IDLE);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                        ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
`else
    // Low address bits below the access size are simply ignored by the lane logic.
    assign w_misalign = 1'b0;
`endif

    assign w_err = (bus.req_size == 2'b11) | w_misalign;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; sub-word stores detour through READ for the merge.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err)                       w_next = S_RESP;
                    else if (!bus.req_we)            w_next = S_READ;
                    else if (bus.req_size == 2'b10)  w_next = S_WRITE;
                    else                             w_next = S_READ;
                end
            end
            S_READ:  w_next = r_we ? S_WRITE : S_RESP;
            S_WRITE: w_next = S_RESP;
            S_RESP:  if (bus.resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        w_byte  = bus.dataOut[{r_lane, 3'b000} +: 8];
        w_half  = r_lane[1] ? bus.dataOut[31:16] : bus.dataOut[15:0];
        w_load  = bus.dataOut;
        w_merge = bus.dataOut;
        unique case (r_size)
            2'b00: begin
                w_load = {{24{r_signed & w_byte[7]}}, w_byte};
                w_merge[{r_lane, 3'b000} +: 8] = r_dataIn[7:0];
            end
            2'b01: begin
                w_load = {{16{r_signed & w_half[15]}}, w_half};
                w_merge[{r_lane[1], 4'b0000} +: 16] = r_dataIn[15:0];
            end
            default: begin
                w_load  = bus.dataOut;
                w_merge = r_dataIn;
            end
        endcase
    end

    // Request capture, memory-side registers and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we      <= 1'b0;
            r_signed  <= 1'b0;
            r_size    <= 2'b00;
            r_lane    <= 2'b00;
            r_address <= '0;
            r_dataIn  <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_wen     <= 1'b0;
        end else begin
            r_wen <= (w_next == S_WRITE);
            if (w_accept) begin
                r_we      <= bus.req_we;
                r_signed  <= bus.req_signed;
                r_size    <= bus.req_size;
                r_lane    <= bus.req_addr[1:0];
                r_address <= bus.req_addr[23:2];
                r_dataIn  <= bus.req_wdata;
                r_rdata   <= '0;
                r_err     <= w_err;
            end
            if (r_state == S_READ) begin
                if (r_we) r_dataIn <= w_merge;
                else      r_rdata  <= w_load;
            end
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.resp_valid  = (r_state == S_RESP);
    assign bus.resp_rdata  = r_rdata;
    assign bus.resp_err    = r_err;
    assign bus.address     = r_address;
    assign bus.dataIn      = r_dataIn;
    assign bus.writeEnable = r_wen;
endmodule
